// File: rtl/foo_model_server.sv
// foo_model_server: create/eval/final responder over a handle table of accumulators.
// Defining FOO_SERVER_STATS_EN adds the stat_evals/stat_errs saturating counters.
module foo_model_server #(
  parameter int MAX_INST = 4,
  parameter int DATA_W = 32,
  parameter int HANDLE_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [HANDLE_W-1:0] cmd_handle,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic                cmd_clk,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [HANDLE_W-1:0] rsp_handle,
  output logic [DATA_W-1:0]   rsp_x,
  output logic                rsp_err
`ifdef FOO_SERVER_STATS_EN
  ,
  output logic [31:0]         stat_evals,
  output logic [15:0]         stat_errs
`endif
);
  localparam logic [1:0] OP_CREATE = 2'd0;
  localparam logic [1:0] OP_EVAL = 2'd1;
  localparam logic [1:0] OP_FINAL = 2'd2;
  logic [MAX_INST-1:0] live, lclk;
  logic [DATA_W-1:0] acc [MAX_INST];
  logic accept, free_ok, sel_live, rise, n_err;
  logic [HANDLE_W-1:0] free_h, n_handle;
  logic [DATA_W-1:0] eval_x, n_x;
  assign cmd_ready = !rsp_valid || rsp_ready;
  assign accept = cmd_valid && cmd_ready;
  always_comb begin
    free_ok = 1'b0;
    free_h = '0;
    for (int i = MAX_INST - 1; i >= 0; i--)
      if (!live[i]) begin
        free_ok = 1'b1;
        free_h = HANDLE_W'(i);
      end
    sel_live = live[cmd_handle];
    rise = cmd_clk && !lclk[cmd_handle];
    eval_x = rise ? acc[cmd_handle] + cmd_a : acc[cmd_handle];
    n_err = cmd_op == OP_CREATE ? !free_ok :
            (cmd_op == OP_EVAL || cmd_op == OP_FINAL) ? !sel_live : 1'b1;
    n_handle = cmd_op == OP_CREATE ? free_h : cmd_handle;
    n_x = (cmd_op == OP_EVAL && sel_live) ? eval_x : '0;
  end
  // The table commits on the accept edge so a back-to-back command sees the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= '0;
      lclk <= '0;
      for (int i = 0; i < MAX_INST; i++) acc[i] <= '0;
      rsp_valid <= 1'b0;
      rsp_handle <= '0;
      rsp_x <= '0;
      rsp_err <= 1'b0;
    end else begin
      assert (HANDLE_W == $clog2(MAX_INST));
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_handle <= n_handle;
        rsp_x <= n_x;
        rsp_err <= n_err;
        if (!n_err) begin
          if (cmd_op == OP_CREATE) begin
            live[free_h] <= 1'b1;
            lclk[free_h] <= 1'b0;
            acc[free_h] <= '0;
          end else if (cmd_op == OP_EVAL) begin
            lclk[cmd_handle] <= cmd_clk;
            acc[cmd_handle] <= eval_x;
          end else begin
            live[cmd_handle] <= 1'b0;
            acc[cmd_handle] <= '0;
          end
        end
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
`ifdef FOO_SERVER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_evals <= '0;
      stat_errs <= '0;
    end else if (accept) begin
      if (cmd_op == OP_EVAL && stat_evals != '1) stat_evals <= stat_evals + 32'd1;
      if (n_err && stat_errs != '1) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_foo_model_server.sv
// tb_foo_model_server: directed bench with a table/queue reference model and per-cycle compare.
module tb_foo_model_server;
  logic clk = 0, rst_n = 1, cmd_valid = 0, cmd_clk = 0, rsp_ready = 1;
  logic [1:0] cmd_op = 0, cmd_handle = 0;
  logic [31:0] cmd_a = 0;
  logic cmd_ready, rsp_valid, rsp_err;
  logic [1:0] rsp_handle;
  logic [31:0] rsp_x;
`ifdef FOO_SERVER_STATS_EN
  logic [31:0] stat_evals;
  logic [15:0] stat_errs;
`endif
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [1:0] h; logic [31:0] x; logic e;} rsp_t;
  rsp_t q[$];
  rsp_t m_r;
  bit m_ok;
  bit m_live[4];
  bit m_clk[4];
  logic [31:0] m_acc[4] = '{default: 32'd0};

  always #5 clk = ~clk;

  foo_model_server dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_handle(cmd_handle), .cmd_a(cmd_a), .cmd_clk(cmd_clk),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_handle(rsp_handle),
    .rsp_x(rsp_x), .rsp_err(rsp_err)
`ifdef FOO_SERVER_STATS_EN
    , .stat_evals(stat_evals), .stat_errs(stat_errs)
`endif
  );

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: apply one request to the instance table and return the response it earns.
  function automatic rsp_t serve(logic [1:0] op, logic [1:0] h, logic [31:0] a, logic c);
    rsp_t r;
    r.h = h;
    r.x = 0;
    r.e = 1;
    if (op == 0) begin
      r.h = 0;
      for (int i = 0; i < 4; i++)
        if (!m_live[i]) begin
          m_live[i] = 1;
          m_clk[i] = 0;
          m_acc[i] = 0;
          r.h = 2'(i);
          r.e = 0;
          break;
        end
    end else if (op == 1 && m_live[h]) begin
      if (c && !m_clk[h]) m_acc[h] = m_acc[h] + a;
      m_clk[h] = c;
      r.x = m_acc[h];
      r.e = 0;
    end else if (op == 2 && m_live[h]) begin
      m_live[h] = 0;
      m_acc[h] = 0;
      r.e = 0;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 4; i++) begin
        m_live[i] = 0;
        m_clk[i] = 0;
        m_acc[i] = 0;
      end
    end else begin
      m_ok = cmd_valid && (q.size() == 0 || rsp_ready);
      if (q.size() != 0 && rsp_ready) void'(q.pop_front());
      if (m_ok) begin
        m_r = serve(cmd_op, cmd_handle, cmd_a, cmd_clk);
        q.push_back(m_r);
      end
    end
  end

  always @(negedge clk)
    if (rst_n) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
      chk("cmd_ready", 32'(cmd_ready), 32'(q.size() == 0 || rsp_ready));
      if (q.size() != 0) begin
        chk("rsp_handle", 32'(rsp_handle), 32'(q[0].h));
        chk("rsp_x", rsp_x, q[0].x);
        chk("rsp_err", 32'(rsp_err), 32'(q[0].e));
      end
    end

  task automatic do_cmd(string name, logic [1:0] op, logic [1:0] h, logic [31:0] a, logic c,
                        logic [1:0] eh, logic [31:0] ex, logic ee);
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = op; cmd_handle = h; cmd_a = a; cmd_clk = c;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    chk({name, " valid"}, 32'(rsp_valid), 32'd1);
    chk({name, " handle"}, 32'(rsp_handle), 32'(eh));
    chk({name, " x"}, rsp_x, ex);
    chk({name, " err"}, 32'(rsp_err), 32'(ee));
  endtask

  task automatic drive(logic [1:0] op, logic [1:0] h, logic [31:0] a, logic c);
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = op; cmd_handle = h; cmd_a = a; cmd_clk = c;
  endtask

  initial begin
    logic ev_clk [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ev_x [5] = '{32'd0, 32'd5, 32'd5, 32'd5, 32'd10};
    #1 rst_n = 0;
    @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_handle", 32'(rsp_handle), 32'd0);
    chk("reset rsp_x", rsp_x, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 4; i++) do_cmd("create", 2'd0, 2'd0, 32'd0, 1'b0, 2'(i), 32'd0, 1'b0);
    do_cmd("create full", 2'd0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) do_cmd("eval h0", 2'd1, 2'd0, 32'd5, ev_clk[i], 2'd0, ev_x[i], 1'b0);
    do_cmd("eval h1 load", 2'd1, 2'd1, 32'hFFFF_FFFE, 1'b1, 2'd1, 32'hFFFF_FFFE, 1'b0);
    do_cmd("eval h1 low", 2'd1, 2'd1, 32'd0, 1'b0, 2'd1, 32'hFFFF_FFFE, 1'b0);
    do_cmd("eval h1 wrap", 2'd1, 2'd1, 32'd3, 1'b1, 2'd1, 32'd1, 1'b0);
    do_cmd("final h2", 2'd2, 2'd2, 32'd0, 1'b0, 2'd2, 32'd0, 1'b0);
    do_cmd("eval freed h2", 2'd1, 2'd2, 32'd1, 1'b1, 2'd2, 32'd0, 1'b1);
    do_cmd("create reuse", 2'd0, 2'd0, 32'd0, 1'b0, 2'd2, 32'd0, 1'b0);
    do_cmd("reserved op", 2'd3, 2'd1, 32'd0, 1'b0, 2'd1, 32'd0, 1'b1);
    do_cmd("eval h1 held", 2'd1, 2'd1, 32'd7, 1'b1, 2'd1, 32'd1, 1'b0);
    do_cmd("final h0", 2'd2, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b0);
    do_cmd("final h0 again", 2'd2, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b1);
    drive(2'd0, 2'd0, 32'd0, 1'b0);
    drive(2'd1, 2'd0, 32'd4, 1'b1);
    drive(2'd1, 2'd0, 32'd4, 1'b0);
    drive(2'd1, 2'd0, 32'd4, 1'b1);
    drive(2'd1, 2'd3, 32'd2, 1'b1);
    @(posedge clk); #1 cmd_valid = 0;
    do_cmd("after burst", 2'd1, 2'd0, 32'd0, 1'b0, 2'd0, 32'd8, 1'b0);
    do_cmd("final h3", 2'd2, 2'd3, 32'd0, 1'b0, 2'd3, 32'd0, 1'b0);
    @(posedge clk); #1;
    rsp_ready = 0; cmd_valid = 1; cmd_op = 0; cmd_handle = 0; cmd_a = 0; cmd_clk = 0;
    @(posedge clk); #1;
    cmd_op = 1; cmd_handle = 3; cmd_a = 9; cmd_clk = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall cmd_ready", 32'(cmd_ready), 32'd0);
      chk("stall handle", 32'(rsp_handle), 32'd3);
      chk("stall x", rsp_x, 32'd0);
      chk("stall err", 32'(rsp_err), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk);
    chk("release valid", 32'(rsp_valid), 32'd1);
    chk("release x", rsp_x, 32'd9);
    chk("release handle", 32'(rsp_handle), 32'd3);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    drive(2'd0, 2'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0; cmd_valid = 0;
    @(negedge clk);
    chk("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1;
    do_cmd("create after reset", 2'd0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
